snoop_bus_arbiter: RTL and testbench

- Owns the shared snoop bus between NCACHE MSI caches.
- Grants one requester at a time, round-robin, and broadcasts its read-miss, write-miss or invalidate message with its address.
- Collects the write-back-done and invalidate-done acknowledgements from every other cache.
- Returns a one-cycle completion pulse to the requester, so a cache never enters MODIFIED or SHARED before its peers have finished.

---
 rtl/snoop_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin owner of the shared MSI snoop bus: broadcasts one request at a time,
// gathers write-back/invalidate acks from the peer caches, then pulses done to the requester.
module snoop_bus_arbiter #(
  parameter int NCACHE    = 2,
  parameter int ADDRWIDTH = 16,
  parameter int TIMEOUT   = 15,
  parameter int TOWIDTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NCACHE-1:0]           reqValid,
  input  logic [2*NCACHE-1:0]         reqType,
  input  logic [ADDRWIDTH*NCACHE-1:0] reqAddr,
  input  logic [NCACHE-1:0]           ackWb,
  input  logic [NCACHE-1:0]           ackInv,
  output logic [NCACHE-1:0]           grant,
  output logic [NCACHE-1:0]           done,
  output logic                        busErr,
  output logic                        bcastValid,
  output logic [1:0]                  bcastType,
  output logic [ADDRWIDTH-1:0]        bcastAddr,
  output logic [NCACHE-1:0]           bcastSrc,
  output logic                        busy
);

  localparam int PW = (NCACHE > 1) ? $clog2(NCACHE) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BCAST   = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [PW-1:0]        ptr_reg, ptr_next;
  logic [TOWIDTH-1:0]   cnt_reg, cnt_next;
  logic [NCACHE-1:0]    wb_seen_reg, wb_seen_next;
  logic [NCACHE-1:0]    inv_seen_reg, inv_seen_next;
  logic [PW-1:0]        src_idx_reg, src_idx_next;
  logic [NCACHE-1:0]    src_reg, src_next;
  logic [1:0]           type_reg, type_next;
  logic [ADDRWIDTH-1:0] addr_reg, addr_next;
  logic                 err_reg, err_next;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        cand_idx;
  logic [1:0]           pick_type;
  logic [ADDRWIDTH-1:0] pick_addr;

  logic [NCACHE-1:0]    wb_now, inv_now, need_ok;
  logic                 met;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 0; k < NCACHE; k++) begin
      cand_idx = PW'((int'(ptr_reg) + k) % NCACHE);
      if (!pick_found && reqValid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_type = reqType[2*int'(pick_idx) +: 2];
    pick_addr = reqAddr[ADDRWIDTH*int'(pick_idx) +: ADDRWIDTH];
  end

  // The source cache never acks its own message, so its bit counts as satisfied.
  for (genvar gi = 0; gi < NCACHE; gi++) begin : g_ack
    assign wb_now[gi]  = wb_seen_reg[gi] | ackWb[gi];
    assign inv_now[gi] = inv_seen_reg[gi] | ackInv[gi];
    assign need_ok[gi] = src_reg[gi] |
                         ((type_reg == 2'd0) ? wb_now[gi] :
                          (type_reg == 2'd1) ? (wb_now[gi] & inv_now[gi]) :
                                               inv_now[gi]);
  end
  assign met = &need_ok;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    wb_seen_next  = wb_seen_reg;
    inv_seen_next = inv_seen_reg;
    src_idx_next  = src_idx_reg;
    src_next      = src_reg;
    type_next     = type_reg;
    addr_next     = addr_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          src_idx_next = pick_idx;
          src_next     = NCACHE'(1) << pick_idx;
          type_next    = pick_type;
          addr_next    = pick_addr;
          if (pick_type == 2'd3) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = BCAST;
          end
        end
      end
      BCAST, COLLECT: begin
        wb_seen_next  = wb_now;
        inv_seen_next = inv_now;
        if (met) begin
          state_next = DONE;
        end else if (state_reg == BCAST) begin
          state_next = COLLECT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == TOWIDTH'(TIMEOUT - 1)) begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: begin
        ptr_next      = (src_idx_reg == PW'(NCACHE - 1)) ? '0 : src_idx_reg + 1'b1;
        cnt_next      = '0;
        wb_seen_next  = '0;
        inv_seen_next = '0;
        err_next      = 1'b0;
        state_next    = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      wb_seen_reg  <= '0;
      inv_seen_reg <= '0;
      src_idx_reg  <= '0;
      src_reg      <= '0;
      type_reg     <= '0;
      addr_reg     <= '0;
      err_reg      <= 1'b0;
      grant        <= '0;
      done         <= '0;
      busErr       <= 1'b0;
      bcastValid   <= 1'b0;
      bcastType    <= '0;
      bcastAddr    <= '0;
      bcastSrc     <= '0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      wb_seen_reg  <= wb_seen_next;
      inv_seen_reg <= inv_seen_next;
      src_idx_reg  <= src_idx_next;
      src_reg      <= src_next;
      type_reg     <= type_next;
      addr_reg     <= addr_next;
      err_reg      <= err_next;
      grant        <= (state_next != IDLE) ? src_next : '0;
      done         <= (state_next == DONE) ? src_next : '0;
      busErr       <= (state_next == DONE) && err_next;
      bcastValid   <= (state_next == BCAST);
      if (state_next == BCAST || state_next == COLLECT) begin
        bcastType <= type_next;
        bcastAddr <= addr_next;
        bcastSrc  <= src_next;
      end else begin
        bcastType <= '0;
        bcastAddr <= '0;
        bcastSrc  <= '0;
      end
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter with NCACHE=2: latency, round-robin order,
// split acks, timeout, illegal type and asynchronous reset abort.
module tb_snoop_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  reqValid;
  logic [3:0]  reqType;
  logic [31:0] reqAddr;
  logic [1:0]  ackWb;
  logic [1:0]  ackInv;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic        busErr;
  logic        bcastValid;
  logic [1:0]  bcastType;
  logic [15:0] bcastAddr;
  logic [1:0]  bcastSrc;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic        two_hot_seen = 1'b0;
  logic        bcast_seen   = 1'b0;

  snoop_bus_arbiter #(
    .NCACHE(2), .ADDRWIDTH(16), .TIMEOUT(15), .TOWIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqType(reqType), .reqAddr(reqAddr),
    .ackWb(ackWb), .ackInv(ackInv),
    .grant(grant), .done(done), .busErr(busErr),
    .bcastValid(bcastValid), .bcastType(bcastType), .bcastAddr(bcastAddr),
    .bcastSrc(bcastSrc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until a done pulse appears or the budget runs out.
  task automatic wait_done(input int budget, output int cycles, output logic [1:0] d, output logic e);
    cycles = 0;
    d      = 2'b00;
    e      = 1'b0;
    while (cycles < budget) begin
      tick();
      cycles++;
      if (grant == 2'b11) two_hot_seen = 1'b1;
      if (bcastValid) bcast_seen = 1'b1;
      if (done != 2'b00) begin
        d = done;
        e = busErr;
        break;
      end
    end
  endtask

  int         cyc;
  logic [1:0] d;
  logic       e;

  initial begin
    reset    = 1'b1;
    reqValid = 2'b00;
    reqType  = 4'b0000;
    reqAddr  = 32'h0;
    ackWb    = 2'b00;
    ackInv   = 2'b00;
    tick();
    tick();
    check_value("reset_outputs", {grant, done, busErr, bcastValid, bcastType, bcastSrc, busy}, 32'h0);
    check_value("reset_addr", {16'h0, bcastAddr}, 32'h0);
    reset = 1'b0;
    tick();

    // Test 1: cache0 readM 0x1234, cache1 acks in the BCAST cycle
    reqValid = 2'b01;
    reqType  = 4'b0000;
    reqAddr  = {16'h0000, 16'h1234};
    tick();
    check_value("t1_bcast", {bcastValid, bcastType, bcastSrc, grant}, {26'h0, 1'b1, 2'd0, 2'b01, 2'b01});
    check_value("t1_addr", {16'h0, bcastAddr}, 32'h1234);
    ackWb = 2'b10;
    tick();
    check_value("t1_done", {done, busErr}, {29'h0, 2'b01, 1'b0});
    check_value("t1_bv_low", {31'h0, bcastValid}, 32'h0);
    ackWb    = 2'b00;
    reqValid = 2'b00;
    tick();
    check_value("t1_idle", {busy, done, grant}, 32'h0);

    // Test 2: fresh reset, both request and keep re-requesting; order must alternate
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    reqValid = 2'b11;
    reqType  = 4'b0000;
    reqAddr  = {16'h0B00, 16'h0A00};
    ackWb    = 2'b11;
    two_hot_seen = 1'b0;
    wait_done(10, cyc, d, e);
    check_value("t2_first", {d, e}, {2'b01, 1'b0});
    check_value("t2_first_lat", cyc, 2);
    wait_done(10, cyc, d, e);
    check_value("t2_second", {d, e}, {2'b10, 1'b0});
    check_value("t2_second_lat", cyc, 3);
    wait_done(10, cyc, d, e);
    check_value("t2_third", {d, e}, {2'b01, 1'b0});
    reqValid = 2'b00;
    ackWb    = 2'b00;
    check_value("t2_never_two_hot", {31'h0, two_hot_seen}, 32'h0);
    tick();

    // Test 3: cache1 writeM 0x00F0; ackWb at T+2, ackInv at T+4 -> done at T+5
    // pointer is now 1 (cache0 was served last)
    reqValid = 2'b10;
    reqType  = 4'b0100;
    reqAddr  = {16'h00F0, 16'h0000};
    tick();
    check_value("t3_bcast", {bcastValid, bcastType, bcastSrc}, {27'h0, 1'b1, 2'd1, 2'b10});
    check_value("t3_addr", {16'h0, bcastAddr}, 32'h00F0);
    tick();
    ackWb = 2'b01;
    check_value("t3_collect", {bcastValid, busy, grant, done}, {26'h0, 1'b0, 1'b1, 2'b10, 2'b00});
    check_value("t3_addr_stable", {16'h0, bcastAddr}, 32'h00F0);
    tick();
    ackWb = 2'b00;
    check_value("t3_wb_only", {30'h0, done}, 32'h0);
    tick();
    ackInv = 2'b01;
    check_value("t3_wb_only2", {30'h0, done}, 32'h0);
    tick();
    ackInv = 2'b00;
    check_value("t3_done", {done, busErr}, {29'h0, 2'b10, 1'b0});
    reqValid = 2'b00;
    tick();
    check_value("t3_idle", {31'h0, busy}, 32'h0);

    // Test 4: cache0 inv with no acks -> timeout after 15 COLLECT cycles
    reqValid = 2'b01;
    reqType  = 4'b0010;
    reqAddr  = {16'h0000, 16'h0BEE};
    tick();
    check_value("t4_bcast", {bcastValid, bcastType, bcastSrc}, {27'h0, 1'b1, 2'd2, 2'b01});
    wait_done(30, cyc, d, e);
    check_value("t4_timeout", {d, e}, {2'b01, 1'b1});
    check_value("t4_timeout_lat", cyc, 16);
    reqValid = 2'b00;
    tick();
    // then cache1 readM served normally
    reqValid = 2'b10;
    reqType  = 4'b0000;
    reqAddr  = {16'h4321, 16'h0000};
    ackWb    = 2'b01;
    wait_done(10, cyc, d, e);
    check_value("t4_after", {d, e}, {2'b10, 1'b0});
    check_value("t4_after_lat", cyc, 2);
    reqValid = 2'b00;
    ackWb    = 2'b00;
    tick();

    // Test 5: illegal type from cache0 -> done+busErr at T+1, never broadcast
    reqValid   = 2'b01;
    reqType    = 4'b0011;
    reqAddr    = {16'h0000, 16'hDEAD};
    bcast_seen = 1'b0;
    wait_done(10, cyc, d, e);
    check_value("t5_illegal", {d, e}, {2'b01, 1'b1});
    check_value("t5_lat", cyc, 1);
    reqValid = 2'b00;
    tick();
    check_value("t5_no_bcast", {31'h0, bcast_seen | bcastValid}, 32'h0);

    // Test 6: reset in COLLECT clears outputs at once; the aborted job never completes
    reqValid = 2'b10;
    reqType  = 4'b1000;
    reqAddr  = {16'h0555, 16'h0000};
    tick();
    tick();
    tick();
    check_value("t6_in_collect", {busy, grant}, {29'h0, 1'b1, 2'b10});
    #2;
    reset = 1'b1;
    #1;
    check_value("t6_async_reset", {grant, done, busErr, bcastValid, bcastType, bcastSrc, busy}, 32'h0);
    reqValid = 2'b11;
    reqType  = 4'b0000;
    reqAddr  = {16'h0B0B, 16'h0A0A};
    ackWb    = 2'b11;
    tick();
    check_value("t6_held_reset", {done, busy}, 32'h0);
    reset = 1'b0;
    wait_done(10, cyc, d, e);
    check_value("t6_after_reset", {d, e}, {2'b01, 1'b0});
    check_value("t6_after_lat", cyc, 2);
    reqValid = 2'b00;
    ackWb    = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
